// File: rtl/add_rr_pipe_if.sv
// Operand read and result write channel bundles for add_rr_pipe.
// Latency: none, these are plain signal bundles.
// Backpressure: per-channel empty (source side) and full (sink side) flags.

// Per-channel operand source: empty flags in, read strobes out, shared data.
interface read_interface #(
   parameter int FLUX = 2,
   parameter int DW   = 27
);
   logic [FLUX-1:0] empty;
   logic [FLUX-1:0] read;
   logic [DW-1:0]   dout;

   modport actor  (input empty, input dout, output read);
   modport source (output empty, output dout, input read);
endinterface

// Per-channel result sink: full flags in, one write strobe and tagged data out.
interface write_interface #(
   parameter int FLUX = 2,
   parameter int DW   = 28
);
   logic [FLUX-1:0] full;
   logic            write;
   logic [DW-1:0]   din;

   modport actor (input full, output write, output din);
   modport sink  (output full, input write, input din);
endinterface

// File: rtl/add_rr_pipe.sv
// add_rr_pipe: round-robin signed adder/subtractor across FLUX operand channel pairs.
// Latency: 1 cycle from operand read to result write.
// Backpressure: a full destination stalls the output stage and blocks all further issue.
module add_rr_pipe #(
   parameter int FLUX       = 2,
   parameter int DATA_WIDTH = 27,
   parameter int SUB        = 0,
   parameter int SAT        = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   read_interface.actor  read_port_opA,
   read_interface.actor  read_port_opB,
   write_interface.actor write_port_sum,
   output logic          sat_pulse
);

   localparam int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 0;
   // Internal tag registers keep at least one bit so FLUX=1 still elaborates.
   localparam int TW        = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
   localparam int RW        = DATA_WIDTH + 1;

   // Output stage and arbitration history.
   logic                  r_stg_valid;
   logic [TW-1:0]         r_stg_tag;
   logic [DATA_WIDTH-1:0] r_stg_data;
   logic                  r_stg_sat;
   logic [TW-1:0]         r_last;

   logic [FLUX-1:0]       w_elig;
   logic                  w_any;
   logic [TW-1:0]         w_win;
   logic                  w_full_stg;
   logic                  w_drain;
   logic                  w_issue;
   logic                  w_write;
   logic [FLUX-1:0]       w_read;
   logic signed [RW-1:0]  w_ext_a;
   logic signed [RW-1:0]  w_ext_b;
   logic signed [RW-1:0]  w_raw;
   logic [DATA_WIDTH-1:0] w_res;
   logic                  w_res_sat;

   // A channel can issue only if both operands are present and its sink has room.
   assign w_elig = ~read_port_opA.empty & ~read_port_opB.empty & ~write_port_sum.full;

   generate
      if (FLUX == 1) begin : g_single
         // Single channel: no arbitration, no tag.
         assign w_full_stg = write_port_sum.full[0];
         assign w_any      = w_elig[0];
         assign w_win      = '0;
      end else begin : g_multi
         logic [TW-1:0] w_idx;
         logic [TW-1:0] w_pick;
         logic          w_found;

         // Round-robin search starting just after the last winner, wrapping once.
         always_comb begin
            w_idx   = '0;
            w_pick  = '0;
            w_found = 1'b0;
            for (int k = 1; k <= FLUX; k++) begin
               w_idx = TW'((int'(r_last) + k) % FLUX);
               if (!w_found && w_elig[w_idx]) begin
                  w_found = 1'b1;
                  w_pick  = w_idx;
               end
            end
         end

         assign w_full_stg = write_port_sum.full[r_stg_tag];
         assign w_any      = w_found;
         assign w_win      = w_pick;
      end
   endgenerate

   // Drain when the held result's sink has room; issue into an empty or draining stage.
   assign w_drain = r_stg_valid & ~w_full_stg;
   assign w_issue = rst_n & (~r_stg_valid | w_drain) & w_any;
   assign w_write = rst_n & w_drain;

   assign w_read              = w_issue ? (FLUX'(1) << w_win) : '0;
   assign read_port_opA.read  = w_read;
   assign read_port_opB.read  = w_read;
   assign write_port_sum.write = w_write;
   assign sat_pulse           = w_write & r_stg_sat;

   generate
      if (FLUX == 1) begin : g_din_single
         assign write_port_sum.din = w_write ? r_stg_data : 'x;
      end else begin : g_din_multi
         assign write_port_sum.din = w_write ? {r_stg_tag, r_stg_data} : 'x;
      end
   endgenerate

   // One extra bit of headroom so overflow is visible before wrap or clamp.
   assign w_ext_a = {read_port_opA.dout[DATA_WIDTH-1], read_port_opA.dout[DATA_WIDTH-1:0]};
   assign w_ext_b = {read_port_opB.dout[DATA_WIDTH-1], read_port_opB.dout[DATA_WIDTH-1:0]};
   assign w_raw   = (SUB != 0) ? (w_ext_a - w_ext_b) : (w_ext_a + w_ext_b);

   // Wrap by truncation, or clamp to the signed range when the top two bits disagree.
   always_comb begin
      w_res     = w_raw[DATA_WIDTH-1:0];
      w_res_sat = 1'b0;
      if ((SAT != 0) && (w_raw[RW-1] != w_raw[RW-2])) begin
         w_res_sat = 1'b1;
         w_res     = w_raw[RW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   end

   // Stage control: load on issue, empty on drain-only, hold while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stg_valid <= 1'b0;
         r_stg_sat   <= 1'b0;
         r_stg_tag   <= '0;
         r_last      <= TW'(FLUX - 1);
      end else if (w_issue) begin
         r_stg_valid <= 1'b1;
         r_stg_sat   <= w_res_sat;
         r_stg_tag   <= w_win;
         r_last      <= w_win;
      end else if (w_drain) begin
         r_stg_valid <= 1'b0;
         r_stg_sat   <= 1'b0;
      end
   end

   // Stage data is qualified by r_stg_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_issue) begin
         r_stg_data <= w_res;
      end
   end

endmodule

// File: tb/tb_add_rr_pipe.sv
// tb_add_rr_pipe: directed checks of add_rr_pipe in three parameterisations.
// Latency: results expected one cycle after the read strobe.
// Backpressure: sink full flags driven directly to exercise stalls.
module tb_add_rr_pipe;

   logic clk;
   logic rst_n;
   logic sat0, sat1, sat2;

   int n_chk;
   int n_bad;

   // d0: FLUX=2 add wrap, d1: FLUX=2 sub wrap, d2: FLUX=4 add saturate
   read_interface  #(.FLUX(2), .DW(27)) a0 ();
   read_interface  #(.FLUX(2), .DW(27)) b0 ();
   write_interface #(.FLUX(2), .DW(28)) w0 ();
   read_interface  #(.FLUX(2), .DW(27)) a1 ();
   read_interface  #(.FLUX(2), .DW(27)) b1 ();
   write_interface #(.FLUX(2), .DW(28)) w1 ();
   read_interface  #(.FLUX(4), .DW(27)) a2 ();
   read_interface  #(.FLUX(4), .DW(27)) b2 ();
   write_interface #(.FLUX(4), .DW(29)) w2 ();

   add_rr_pipe #(.FLUX(2), .DATA_WIDTH(27), .SUB(0), .SAT(0)) u_d0 (
      .clk(clk), .rst_n(rst_n), .read_port_opA(a0), .read_port_opB(b0),
      .write_port_sum(w0), .sat_pulse(sat0));
   add_rr_pipe #(.FLUX(2), .DATA_WIDTH(27), .SUB(1), .SAT(0)) u_d1 (
      .clk(clk), .rst_n(rst_n), .read_port_opA(a1), .read_port_opB(b1),
      .write_port_sum(w1), .sat_pulse(sat1));
   add_rr_pipe #(.FLUX(4), .DATA_WIDTH(27), .SUB(0), .SAT(1)) u_d2 (
      .clk(clk), .rst_n(rst_n), .read_port_opA(a2), .read_port_opB(b2),
      .write_port_sum(w2), .sat_pulse(sat2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic d0_in(input logic [1:0] emp, input logic [26:0] da, input logic [26:0] db);
      a0.empty = emp; b0.empty = emp; a0.dout = da; b0.dout = db;
   endtask

   task automatic d2_in(input logic [3:0] emp, input logic [26:0] da, input logic [26:0] db);
      a2.empty = emp; b2.empty = emp; a2.dout = da; b2.dout = db;
   endtask

   initial begin
      logic [27:0] e28;
      n_chk = 0;
      n_bad = 0;
      rst_n = 1'b0;
      d0_in(2'b11, '0, '0);
      a1.empty = 2'b11; b1.empty = 2'b11; a1.dout = '0; b1.dout = '0;
      d2_in(4'hF, '0, '0);
      w0.full = '0; w1.full = '0; w2.full = '0;
      tick();
      tick();

      // Reset: eligible channels must not be read while reset is sampled
      d0_in(2'b00, 27'd1, 27'd1);
      #2;
      chk("rst_read", a0.read, 2'b00);
      chk("rst_write", w0.write, 1'b0);
      chk("rst_sat", sat2, 1'b0);
      tick();
      rst_n = 1'b1;

      // Round robin on d0, both channels eligible for four cycles
      for (int k = 0; k < 6; k++) begin
         d0_in((k < 4) ? 2'b00 : 2'b11, 27'(100 * (k + 1)), 27'(k + 3));
         #2;
         chk("rr_read_a", a0.read, (k < 4) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
         chk("rr_read_b", b0.read, (k < 4) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
         chk("rr_write", w0.write, (k >= 1 && k <= 4) ? 1'b1 : 1'b0);
         if (k >= 1 && k <= 4) begin
            e28 = {1'((k - 1) % 2), 27'(100 * k + k + 2)};
            chk("rr_din", w0.din, e28);
         end
         tick();
      end

      // 5 + (-7) on d0 and 5 - (-7) on d1, channel 0
      d0_in(2'b10, 27'd5, 27'(-7));
      a1.empty = 2'b10; b1.empty = 2'b10; a1.dout = 27'd5; b1.dout = 27'(-7);
      #2;
      chk("arith_read0", a0.read, 2'b01);
      chk("arith_read1", a1.read, 2'b01);
      tick();
      d0_in(2'b11, '0, '0);
      a1.empty = 2'b11; b1.empty = 2'b11;
      #2;
      chk("add_write", w0.write, 1'b1);
      chk("add_din", w0.din, {1'b0, 27'h7FFFFFE});
      chk("sub_write", w1.write, 1'b1);
      chk("sub_din", w1.din, {1'b0, 27'd12});
      tick();

      // Positive overflow: d2 clamps, d0 wraps
      d2_in(4'b1110, 27'h3FFFFFF, 27'h3FFFFFF);
      d0_in(2'b10, 27'h3FFFFFF, 27'h3FFFFFF);
      #2;
      chk("sat_read2", a2.read, 4'b0001);
      chk("sat_idle_pulse", sat2, 1'b0);
      tick();
      // Negative overflow issued back to back on d2
      d2_in(4'b1110, 27'h4000000, 27'h4000000);
      d0_in(2'b11, '0, '0);
      #2;
      chk("satp_din", w2.din, {2'b00, 27'h3FFFFFF});
      chk("satp_pulse", sat2, 1'b1);
      chk("wrap_din", w0.din, {1'b0, 27'h7FFFFFE});
      chk("wrap_pulse", sat0, 1'b0);
      tick();
      d2_in(4'b1110, 27'd3, 27'd4);
      #2;
      chk("satn_din", w2.din, {2'b00, 27'h4000000});
      chk("satn_pulse", sat2, 1'b1);
      tick();
      d2_in(4'hF, '0, '0);
      #2;
      chk("nosat_din", w2.din, {2'b00, 27'd7});
      chk("nosat_pulse", sat2, 1'b0);
      tick();

      // FLUX=4: set last=3, then channels 1 and 3 eligible
      d2_in(4'b0111, 27'd1, 27'd2);
      #2;
      chk("rr4_prime", a2.read, 4'b1000);
      tick();
      d2_in(4'b0101, 27'd10, 27'd20);
      #2;
      chk("rr4_first", a2.read, 4'b0010);
      chk("rr4_w0", w2.din, {2'd3, 27'd3});
      tick();
      d2_in(4'b0101, 27'd30, 27'd40);
      #2;
      chk("rr4_second", b2.read, 4'b1000);
      chk("rr4_w1", w2.din, {2'd1, 27'd30});
      tick();
      d2_in(4'hF, '0, '0);
      #2;
      chk("rr4_idle", a2.read, 4'b0000);
      chk("rr4_w2", w2.din, {2'd3, 27'd70});
      tick();

      // Stall: stage holds tag 1 with full[1]=1 while channel 0 waits
      d0_in(2'b01, 27'd7, 27'd8);
      #2;
      chk("stall_issue", a0.read, 2'b10);
      tick();
      for (int s = 0; s < 3; s++) begin
         d0_in(2'b00, 27'd99, 27'd99);
         w0.full = 2'b10;
         #2;
         chk("stall_write", w0.write, 1'b0);
         chk("stall_read_a", a0.read, 2'b00);
         chk("stall_read_b", b0.read, 2'b00);
         tick();
      end
      d0_in(2'b00, 27'd20, 27'd1);
      w0.full = 2'b00;
      #2;
      chk("unstall_write", w0.write, 1'b1);
      chk("unstall_din", w0.din, {1'b1, 27'd15});
      chk("unstall_read", a0.read, 2'b01);
      tick();
      d0_in(2'b11, '0, '0);
      #2;
      chk("after_stall_din", w0.din, {1'b0, 27'd21});
      tick();

      // Reset one cycle after an issue discards the held result
      d0_in(2'b01, 27'd50, 27'd50);
      #2;
      chk("pre_rst_read", a0.read, 2'b10);
      tick();
      rst_n = 1'b0;
      d0_in(2'b11, '0, '0);
      #2;
      chk("midrst_write", w0.write, 1'b0);
      chk("midrst_sat", sat0, 1'b0);
      tick();
      rst_n = 1'b1;
      d0_in(2'b00, 27'd1, 27'd2);
      #2;
      chk("postrst_write", w0.write, 1'b0);
      chk("postrst_read", a0.read, 2'b01);
      tick();
      d0_in(2'b11, '0, '0);
      #2;
      chk("postrst_wr1", w0.write, 1'b1);
      chk("postrst_din", w0.din, {1'b0, 27'd3});
      tick();
      #2;
      chk("final_idle", w0.write, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
